// File: rtl/life_update_sched_if.sv
// Handshake bundle between the Life board sequencer and its datapath.
// next_alive exists only when LIFE_SCHED_EXTINCT_EN is defined.
interface life_update_sched_if #(
  parameter int CELL_BITS = 6,
  parameter int GEN_W     = 16
);
  logic                 frame_tick;
  logic                 run_en;
  logic                 step_req;
  logic                 seed_req;
`ifdef LIFE_SCHED_EXTINCT_EN
  logic                 next_alive;
`endif
  logic [CELL_BITS-1:0] cell_addr;
  logic                 seed_we;
  logic                 snap_we;
  logic                 calc_we;
  logic                 busy;
  logic                 gen_done;
  logic [GEN_W-1:0]     gen_count;

`ifdef LIFE_SCHED_EXTINCT_EN
  modport master (
    output frame_tick, run_en, step_req, seed_req, next_alive,
    input  cell_addr, seed_we, snap_we, calc_we, busy, gen_done, gen_count
  );
  modport slave (
    input  frame_tick, run_en, step_req, seed_req, next_alive,
    output cell_addr, seed_we, snap_we, calc_we, busy, gen_done, gen_count
  );
`else
  modport master (
    output frame_tick, run_en, step_req, seed_req,
    input  cell_addr, seed_we, snap_we, calc_we, busy, gen_done, gen_count
  );
  modport slave (
    input  frame_tick, run_en, step_req, seed_req,
    output cell_addr, seed_we, snap_we, calc_we, busy, gen_done, gen_count
  );
`endif
endinterface

// File: rtl/life_update_sched.sv
// Generation sequencer for the 8x8 Life board (seed / snap / calc sweeps).
// Define LIFE_SCHED_EXTINCT_EN to auto-reseed after an all-dead generation.
module life_update_sched #(
  parameter int CELL_BITS      = 6,
  parameter int FRAMES_PER_GEN = 8,
  parameter int GEN_W          = 16
) (
  input logic               clk,
  input logic               rst_n,
  life_update_sched_if.slave bus
);
  localparam int DIV_W = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;
  localparam logic [DIV_W-1:0] DIV_TOP = DIV_W'(FRAMES_PER_GEN - 1);
  localparam logic [CELL_BITS-1:0] LAST = {CELL_BITS{1'b1}};

  typedef enum logic [2:0] {
    IDLE, SEED, SNAP, CALC, DONE
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CELL_BITS-1:0] r_addr;
  logic [DIV_W-1:0]     r_div;
  logic [GEN_W-1:0]     r_gen;
  logic                 r_step_pend;
  logic                 r_seed_pend;
  logic                 w_tick;
  logic                 w_run_trig;
  logic                 w_start_seed;
  logic                 w_start_gen;
  logic                 w_sweep;
  logic                 w_last;
  logic                 w_extinct;

  assign w_tick       = (r_state == IDLE) && bus.frame_tick;
  assign w_run_trig   = w_tick && bus.run_en && (r_div == DIV_TOP);
  assign w_start_seed = w_tick && r_seed_pend;
  assign w_start_gen  = w_tick && !r_seed_pend &&
                        (w_run_trig || r_step_pend);
  assign w_sweep      = (r_state == SEED) || (r_state == SNAP) ||
                        (r_state == CALC);
  assign w_last       = (r_addr == LAST);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_start_seed)     w_next = SEED;
        else if (w_start_gen) w_next = SNAP;
      end
      SEED:    if (w_last) w_next = IDLE;
      SNAP:    if (w_last) w_next = CALC;
      CALC:    if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

`ifdef LIFE_SCHED_EXTINCT_EN
  logic r_alive;

  // prev is frozen during CALC, so OR-ing the written bits sees the whole board
  always_ff @(posedge clk) begin
    if (!rst_n)                                r_alive <= 1'b0;
    else if (r_state == SNAP)                  r_alive <= 1'b0;
    else if (r_state == CALC && bus.next_alive) r_alive <= 1'b1;
  end

  assign w_extinct = (r_state == DONE) && !r_alive;
`else
  assign w_extinct = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_div       <= '0;
      r_gen       <= '0;
      r_step_pend <= 1'b0;
      r_seed_pend <= 1'b1;
    end else begin
      r_state <= w_next;
      // the address wraps to 0 on the last cell, ready for the next phase
      r_addr  <= w_sweep ? r_addr + 1'b1 : '0;
      if (w_start_seed)
        r_div <= '0;
      else if (w_tick && bus.run_en)
        r_div <= w_run_trig ? '0 : r_div + 1'b1;
      r_step_pend <= (r_step_pend && !w_start_gen) || bus.step_req;
      r_seed_pend <= (r_seed_pend && !w_start_seed) || bus.seed_req ||
                     w_extinct;
      if (r_state == SEED && w_last)
        r_gen <= '0;
      else if (r_state == DONE)
        r_gen <= r_gen + 1'b1;
    end
  end

  assign bus.cell_addr = r_addr;
  assign bus.seed_we   = (r_state == SEED);
  assign bus.snap_we   = (r_state == SNAP);
  assign bus.calc_we   = (r_state == CALC);
  assign bus.busy      = (r_state != IDLE);
  assign bus.gen_done  = (r_state == DONE);
  assign bus.gen_count = r_gen;
endmodule

// File: tb/tb_life_update_sched.sv
// Bench for life_update_sched: directed scenarios plus random traffic,
// every cycle compared against a job/offset model of the sequencer.
module tb_life_update_sched;
  localparam int CB  = 6;
  localparam int N   = 1 << CB;
  localparam int FPG = 4;
  localparam int GW  = 4;
  localparam int VW  = 5 + CB + GW;
`ifdef LIFE_SCHED_EXTINCT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  life_update_sched_if #(.CELL_BITS(CB), .GEN_W(GW)) bus ();

  life_update_sched #(
    .CELL_BITS(CB), .FRAMES_PER_GEN(FPG), .GEN_W(GW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  logic [VW-1:0] dut_vec;
  assign dut_vec = {bus.busy, bus.seed_we, bus.snap_we, bus.calc_we,
                    bus.gen_done, bus.cell_addr, bus.gen_count};

  int n_checks = 0;
  int n_fail = 0;

  // model: job 0=none 1=seed 2=generation, m_t = cycle offset inside job
  int m_job = 0;
  int m_t = 0;
  int m_cnt = 0;
  int m_div = 0;
  bit m_step = 0;
  bit m_seed = 1;
  bit m_alive = 0;

  function automatic void model_step(bit ft, bit re, bit sr, bit sd,
                                     bit na, bit rs);
    bit trig;
    trig = 0;
    if (!rs) begin
      m_job = 0; m_t = 0; m_cnt = 0; m_div = 0;
      m_step = 0; m_seed = 1; m_alive = 0;
      return;
    end
    case (m_job)
      0: if (ft) begin
        if (re) begin
          trig = (m_div == FPG - 1);
          m_div = (m_div + 1) % FPG;
        end
        if (m_seed) begin
          m_job = 1; m_t = 0; m_seed = 0; m_div = 0;
        end else if (trig || m_step) begin
          m_job = 2; m_t = 0; m_step = 0; m_alive = 0;
        end
      end
      1: begin
        if (m_t == N - 1) begin m_job = 0; m_t = 0; m_cnt = 0; end
        else m_t++;
      end
      default: begin
        if (m_t >= N && m_t < 2 * N && na) m_alive = 1;
        if (m_t == 2 * N) begin
          m_job = 0; m_t = 0;
          m_cnt = (m_cnt + 1) % (1 << GW);
          if (EXT && !m_alive) m_seed = 1;
        end else m_t++;
      end
    endcase
    if (sr) m_step = 1;
    if (sd) m_seed = 1;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic b, s, p, c, d;
    logic [CB-1:0] a;
    b = (m_job != 0);
    s = (m_job == 1);
    p = (m_job == 2) && (m_t < N);
    c = (m_job == 2) && (m_t >= N) && (m_t < 2 * N);
    d = (m_job == 2) && (m_t == 2 * N);
    a = (s || p) ? CB'(m_t) : c ? CB'(m_t - N) : '0;
    return {b, s, p, c, d, a, GW'(m_cnt)};
  endfunction

  task automatic cyc(input bit ft, input bit re, input bit sr,
                     input bit sd, input bit na, input bit rs);
    bus.frame_tick = ft;
    bus.run_en     = re;
    bus.step_req   = sr;
    bus.seed_req   = sd;
`ifdef LIFE_SCHED_EXTINCT_EN
    bus.next_alive = na;
`endif
    rst_n = rs;
    @(posedge clk);
    model_step(ft, re, sr, sd, na, rs);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc($urandom % 2, $urandom % 2, $urandom % 2, $urandom % 2, 1, 0);
      @(negedge clk);
      n_checks++;
      if (dut_vec !== '0) begin
        n_fail++;
        $display("FAIL reset got=%h want=0", dut_vec);
      end
    end
  endtask

  task automatic test_seed();
    int ns = 0;
    int nd = 0;
    for (int i = 0; i < 70; i++) begin
      cyc(i == 0, 0, 0, 0, 1, 1);
      @(negedge clk);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL seed i=%0d dut=%h model=%h", i, dut_vec, exp_vec());
      end
      if (bus.seed_we && bus.cell_addr !== CB'(ns)) begin
        n_fail++;
        $display("FAIL seed_addr got=%0d want=%0d", bus.cell_addr, ns);
      end
      ns += int'(bus.seed_we);
      nd += int'(bus.gen_done);
    end
    n_checks++;
    if (ns != N || nd != 0 || bus.gen_count !== '0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL seed_sum we=%0d done=%0d cnt=%0d busy=%b want 64/0/0/0",
               ns, nd, bus.gen_count, bus.busy);
    end
  endtask

  task automatic test_step();
    int nb = 0, np = 0, nc = 0, nd = 0;
    for (int i = 0; i < 150; i++) begin
      cyc(i == 2 || i == 140, 0, i == 0, 0, 1, 1);
      @(negedge clk);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL step i=%0d dut=%h model=%h", i, dut_vec, exp_vec());
      end
      nb += int'(bus.busy);
      np += int'(bus.snap_we);
      nc += int'(bus.calc_we);
      nd += int'(bus.gen_done);
    end
    n_checks++;
    if (nb != 2 * N + 1 || np != N || nc != N || nd != 1 ||
        bus.gen_count !== GW'(1)) begin
      n_fail++;
      $display("FAIL step_sum busy=%0d snap=%0d calc=%0d done=%0d cnt=%0d want 129/64/64/1/1",
               nb, np, nc, nd, bus.gen_count);
    end
  endtask

  task automatic test_run();
    int starts[$];
    bit pb = 0;
    for (int i = 0; i < 1800; i++) begin
      cyc(i == 2 || (i >= 100 && (i - 100) % 140 == 0 && i < 100 + 12 * 140),
          1, 0, i == 0, 1, 1);
      @(negedge clk);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL run i=%0d dut=%h model=%h", i, dut_vec, exp_vec());
      end
      if (i >= 100 && bus.busy && !pb) starts.push_back((i - 100) / 140 + 1);
      pb = bus.busy;
    end
    n_checks++;
    if (starts.size() != 3 || bus.gen_count !== GW'(3)) begin
      n_fail++;
      $display("FAIL run_count gens=%0d cnt=%0d want 3/3",
               starts.size(), bus.gen_count);
    end else begin
      n_checks++;
      if (starts[0] != 4 || starts[1] != 8 || starts[2] != 12) begin
        n_fail++;
        $display("FAIL run_ticks got=%0d,%0d,%0d want 4,8,12",
                 starts[0], starts[1], starts[2]);
      end
    end
  endtask

  task automatic test_busy_reqs();
    int ns = 0, ng = 0;
    bit ps = 0, pp = 0;
    for (int i = 0; i < 450; i++) begin
      cyc(i == 1 || i == 200 || i == 300, 0, i == 0 || i == 80, i == 90, 1, 1);
      @(negedge clk);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL busyreq i=%0d dut=%h model=%h", i, dut_vec, exp_vec());
      end
      if (bus.seed_we && !ps) ns++;
      if (bus.snap_we && !pp) ng++;
      ps = bus.seed_we;
      pp = bus.snap_we;
      if (i == 280) begin
        n_checks++;
        if (bus.gen_count !== '0 || ng != 1 || ns != 1) begin
          n_fail++;
          $display("FAIL busyreq_seed cnt=%0d gens=%0d seeds=%0d want 0/1/1",
                   bus.gen_count, ng, ns);
        end
      end
    end
    n_checks++;
    if (ns != 1 || ng != 2 || bus.gen_count !== GW'(1)) begin
      n_fail++;
      $display("FAIL busyreq_sum seeds=%0d gens=%0d cnt=%0d want 1/2/1",
               ns, ng, bus.gen_count);
    end
  endtask

  task automatic test_wrap();
    int nd = 0;
    bit pd = 0;
    for (int i = 0; i < 16 * 140; i++) begin
      cyc(i % 140 == 1, 0, i % 140 == 0, 0, 1, 1);
      @(negedge clk);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL wrap i=%0d dut=%h model=%h", i, dut_vec, exp_vec());
      end
      if (pd) begin
        n_checks++;
        if (bus.gen_count !== GW'((1 + nd) % 16)) begin
          n_fail++;
          $display("FAIL wrap_cnt got=%0d want=%0d",
                   bus.gen_count, (1 + nd) % 16);
        end
      end
      pd = bus.gen_done;
      nd += int'(bus.gen_done);
    end
    n_checks++;
    if (nd != 16) begin
      n_fail++;
      $display("FAIL wrap_gens got=%0d want=16", nd);
    end
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      cyc(i == 1, 0, i == 0, 0, 1, 1);
      @(negedge clk);
      if (bus.snap_we && bus.cell_addr == CB'(20)) hit = 1;
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL rstmid_reach got=no_addr20 want=addr20");
    end
    cyc(0, 0, 0, 0, 1, 0);
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.snap_we !== 1'b0 || bus.cell_addr !== '0 ||
        bus.gen_count !== '0) begin
      n_fail++;
      $display("FAIL rstmid busy=%b snap=%b addr=%0d cnt=%0d want 0/0/0/0",
               bus.busy, bus.snap_we, bus.cell_addr, bus.gen_count);
    end
  endtask

  task automatic test_extinct();
    int ns = 0;
    bit ps = 0;
    for (int i = 0; i < 400; i++) begin
      cyc(i == 0 || i == 101 || i == 300, 0, i == 100, 0, 0, 1);
      @(negedge clk);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL extinct i=%0d dut=%h model=%h", i, dut_vec, exp_vec());
      end
      if (bus.seed_we && !ps) ns++;
      ps = bus.seed_we;
      if (i == 250) begin
        n_checks++;
        if (bus.gen_count !== GW'(1)) begin
          n_fail++;
          $display("FAIL extinct_gen cnt=%0d want=1", bus.gen_count);
        end
      end
    end
    n_checks++;
    if (ns != (EXT ? 2 : 1) || bus.gen_count !== GW'(EXT ? 0 : 1)) begin
      n_fail++;
      $display("FAIL extinct_sum seeds=%0d cnt=%0d want %0d/%0d",
               ns, bus.gen_count, EXT ? 2 : 1, EXT ? 0 : 1);
    end
  endtask

  task automatic test_random();
    bit re = 0;
    int p_alive = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 300 == 0) begin
        re = $urandom % 2;
        p_alive = (i / 300) % 3 == 0 ? 0 : ((i / 300) % 3 == 1 ? 2 : 50);
      end
      cyc($urandom % 20 == 0, re, $urandom % 200 == 0, $urandom % 400 == 0,
          int'($urandom % 100) < p_alive, $urandom % 1500 != 0);
      @(negedge clk);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL random i=%0d dut=%h model=%h", i, dut_vec, exp_vec());
      end
      n_checks++;
      if (int'(bus.seed_we) + int'(bus.snap_we) + int'(bus.calc_we) > 1) begin
        n_fail++;
        $display("FAIL onehot_we got=%b%b%b want<=1 high",
                 bus.seed_we, bus.snap_we, bus.calc_we);
      end
    end
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.run_en     = 1'b0;
    bus.step_req   = 1'b0;
    bus.seed_req   = 1'b0;
`ifdef LIFE_SCHED_EXTINCT_EN
    bus.next_alive = 1'b1;
`endif
    test_reset();
    test_seed();
    test_step();
    test_run();
    test_busy_reqs();
    test_wrap();
    test_reset_mid();
    test_extinct();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
